// File: rtl/prog_ram_fetch.sv
// Program RAM and sequential instruction fetch for the LED CPU.
// Program mode absorbs the switch/enter write stream into a 2^ADDR_W x DATA_W
// RAM and tracks the programmed length. Run mode walks the program from
// address 0 and offers each word on a valid/ready handshake. Wrap-around and
// jumps are supported.
module prog_ram_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] addrWr,
    input  logic [DATA_W-1:0] dataWr,
    input  logic              WrEn,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   prog_len
);

    typedef enum logic [1:0] {PROG, FETCH, PRESENT} state_t;

    state_t            state_q;
    logic              instr_valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W:0]   prog_len_q;

    // No reset on the array: contents survive rst and a mode switch.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Lengths and addresses are compared one bit wider so address 255 maps
    // to a length of 256 rather than wrapping to 0.
    logic [ADDR_W:0] wr_len;
    logic [ADDR_W:0] pc_inc;
    logic [ADDR_W:0] jump_ext;

    assign wr_len   = {1'b0, addrWr} + (ADDR_W+1)'(1);
    assign pc_inc   = {1'b0, pc_q} + (ADDR_W+1)'(1);
    assign jump_ext = {1'b0, jump_addr};

    logic wr_fire;
    assign wr_fire = !rst && (state_q == PROG) && WrEn;

    // Next PC after a handshake: valid jump, out-of-range jump, wrap, step.
    always_comb begin
        pc_d = pc_inc[ADDR_W-1:0];
        if (jump_en) begin
            pc_d = (jump_ext < prog_len_q) ? jump_addr : '0;
        end else if (pc_inc == prog_len_q) begin
            pc_d = '0;
        end
    end

    // RAM write port; only the programming stream in PROG can write.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[addrWr] <= dataWr;
        end
    end

    // Control FSM with registered outputs; the RAM read lands directly in instr_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PROG;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            pc_q          <= '0;
            prog_len_q    <= '0;
        end else begin
            case (state_q)
                PROG: begin
                    if (WrEn && (wr_len > prog_len_q)) begin
                        prog_len_q <= wr_len;
                    end
                    if (run) begin
                        state_q <= FETCH;
                        pc_q    <= '0;
                    end
                end
                FETCH: begin
                    if (!run) begin
                        state_q <= PROG;
                        pc_q    <= '0;
                    end else if (prog_len_q != '0) begin
                        instr_q       <= mem_q[pc_q];
                        instr_valid_q <= 1'b1;
                        state_q       <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Leaving run mode drops the pending word without a handshake.
                    if (!run) begin
                        state_q       <= PROG;
                        instr_valid_q <= 1'b0;
                        pc_q          <= '0;
                    end else if (instr_ready) begin
                        state_q       <= FETCH;
                        instr_valid_q <= 1'b0;
                        pc_q          <= pc_d;
                    end
                end
                default: begin
                    state_q       <= PROG;
                    instr_valid_q <= 1'b0;
                    pc_q          <= '0;
                end
            endcase
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_prog_ram_fetch.sv
// Directed bench for prog_ram_fetch: expected words are queued as stimulus is
// set up and compared when the DUT presents them.
module tb_prog_ram_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  addrWr;
    logic [15:0] dataWr;
    logic        WrEn;
    logic        instr_ready;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [8:0]  prog_len;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    prog_ram_fetch #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .addrWr     (addrWr),
        .dataWr     (dataWr),
        .WrEn       (WrEn),
        .instr_ready(instr_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .instr_valid(instr_valid),
        .instr      (instr),
        .pc         (pc),
        .prog_len   (prog_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One word written twice: upper byte first, then the full word.
    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        addrWr = a; dataWr = {d[15:8], 8'h00}; WrEn = 1'b1;
        @(negedge clk);
        dataWr = d;
        @(negedge clk);
        WrEn = 1'b0;
    endtask

    // Wait (bounded) for the next presented word and compare it to the queue head.
    task automatic expect_next(input string tag, output int lat);
        exp_t e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!instr_valid && lat < 8);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
            chk({tag, "_instr"}, 32'(instr), 32'(e.instr));
            chk({tag, "_pc"},    32'(pc),    32'(e.pc));
        end
    endtask

    initial begin
        int lat;
        int seen_valid;
        rst = 1'b1; run = 1'b0; addrWr = '0; dataWr = '0; WrEn = 1'b0;
        instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_valid",    32'(instr_valid), 32'd0);
        chk("reset_instr",    32'(instr),       32'd0);
        chk("reset_pc",       32'(pc),          32'd0);
        chk("reset_prog_len", 32'(prog_len),    32'd0);

        // Run with nothing programmed: never valid.
        run = 1'b1;
        seen_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (instr_valid) seen_valid++;
        end
        chk("empty_run_valid", 32'(seen_valid), 32'd0);
        run = 1'b0;
        @(negedge clk);

        // Program three words.
        wr(8'd0, 16'h1111);
        wr(8'd1, 16'h2222);
        wr(8'd2, 16'h3333);
        chk("prog_len_3", 32'(prog_len), 32'd3);

        // Sequential stream with wrap; each word 2 cycles after the previous.
        instr_ready = 1'b1;
        run = 1'b1;
        sb.push_back('{16'h1111, 8'd0});
        sb.push_back('{16'h2222, 8'd1});
        sb.push_back('{16'h3333, 8'd2});
        sb.push_back('{16'h1111, 8'd0});
        for (int i = 0; i < 4; i++) begin
            expect_next($sformatf("seq%0d", i), lat);
            chk($sformatf("seq%0d_lat", i), 32'(lat), 32'd2);
        end

        // Stall at pc=1 for 5 cycles.
        @(negedge clk);
        instr_ready = 1'b0;
        sb.push_back('{16'h2222, 8'd1});
        expect_next("stall0", lat);
        repeat (4) begin
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr),       32'h2222);
            chk("stall_pc",    32'(pc),          32'd1);
        end
        instr_ready = 1'b1;
        sb.push_back('{16'h3333, 8'd2});
        expect_next("after_stall", lat);
        chk("after_stall_lat", 32'(lat), 32'd2);
        sb.push_back('{16'h1111, 8'd0});
        expect_next("wrap", lat);

        // In-range jump from pc=0 to 2.
        jump_en = 1'b1; jump_addr = 8'd2;
        sb.push_back('{16'h3333, 8'd2});
        expect_next("jump2", lat);
        chk("jump2_lat", 32'(lat), 32'd2);
        jump_en = 1'b0;
        sb.push_back('{16'h1111, 8'd0});
        expect_next("wrap2", lat);

        // Out-of-range jump falls back to 0.
        jump_en = 1'b1; jump_addr = 8'd7;
        sb.push_back('{16'h1111, 8'd0});
        expect_next("jump7", lat);
        jump_en = 1'b0;

        // Drop back to program mode while presenting.
        run = 1'b0;
        @(negedge clk);
        chk("drop_valid", 32'(instr_valid), 32'd0);
        chk("drop_pc",    32'(pc),          32'd0);
        chk("drop_len",   32'(prog_len),    32'd3);
        wr(8'd5, 16'hABCD);
        chk("prog_len_6", 32'(prog_len), 32'd6);

        // Restart from 0; run-mode writes must be ignored.
        run = 1'b1;
        sb.push_back('{16'h1111, 8'd0});
        expect_next("restart", lat);
        chk("restart_lat", 32'(lat), 32'd2);
        WrEn = 1'b1; addrWr = 8'd0; dataWr = 16'hFFFF;
        jump_en = 1'b1; jump_addr = 8'd5;
        sb.push_back('{16'hABCD, 8'd5});
        @(negedge clk);
        addrWr = 8'd9;
        expect_next("jump5", lat);
        WrEn = 1'b0;
        jump_addr = 8'd0;
        sb.push_back('{16'h1111, 8'd0});
        expect_next("ram0_kept", lat);
        jump_en = 1'b0;
        chk("run_wr_len", 32'(prog_len), 32'd6);

        // Reset while presenting.
        rst = 1'b1; run = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr),       32'd0);
        chk("rst_pc",    32'(pc),          32'd0);
        chk("rst_len",   32'(prog_len),    32'd0);
        rst = 1'b0;

        // Top address gives a 9-bit length; old RAM still readable.
        wr(8'd255, 16'h5A5A);
        chk("prog_len_256", 32'(prog_len), 32'd256);
        run = 1'b1;
        sb.push_back('{16'h1111, 8'd0});
        expect_next("post_rst", lat);
        chk("post_rst_lat", 32'(lat), 32'd2);
        run = 1'b0;
        @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
